// File: rtl/wb_frame_fetch_pkg.sv
// Shared definitions for the Wishbone frame fetcher: FSM state encoding and
// default widths used by the fetcher and its output FIFO.
package wb_frame_fetch_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_FIFO_AW    = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/wb_frame_fetch_sync_fifo.sv
// Synchronous first-word fall-through FIFO with level/empty/full flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
  import wb_frame_fetch_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int AW    = DEF_FIFO_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Requests against a full or empty FIFO are dropped rather than corrupting state.
  assign do_push_s = push_i & (level_q != LVL_FULL);
  assign do_pop_s  = pop_i & (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; validity is tracked by the level counter.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_FULL);
  assign level_o = level_q;

endmodule

// File: rtl/wb_frame_fetch.sv
// Wishbone read master: fetches a contiguous block of words from the frame
// memory and streams them out through a small FWFT FIFO.
module wb_frame_fetch
  import wb_frame_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FIFO_AW    = DEF_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] wbm_address,
  output logic [DATA_WIDTH-1:0] wbm_writedata,
  input  logic [DATA_WIDTH-1:0] wbm_readdata,
  output logic                  wbm_strobe,
  output logic                  wbm_cycle,
  output logic                  wbm_write,
  input  logic                  wbm_ack,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FIFO_AW:0]      fifo_level
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  remain_q;
  logic                  stop_pend_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  stb_q;

  logic                  fifo_push_s;
  logic                  fifo_pop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FIFO_AW:0]      fifo_level_s;

  // REQ is only entered with a free slot, so this push can never overflow.
  assign fifo_push_s = (state_q == S_REQ) & wbm_ack;
  assign fifo_pop_s  = out_ready & ~fifo_empty_s;

  // Fetch sequencer: one outstanding read, strobe dropped for a GAP cycle after every ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          stop_pend_q <= 1'b0;
          if (start) begin
            if (word_count != '0) begin
              addr_q   <= base_addr;
              remain_q <= word_count;
              busy_q   <= 1'b1;
              if (fifo_full_s) begin
                state_q <= S_GAP;
                stb_q   <= 1'b0;
              end else begin
                state_q <= S_REQ;
                stb_q   <= 1'b1;
              end
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (stop) begin
            stop_pend_q <= 1'b1;
          end
          if (wbm_ack) begin
            addr_q   <= addr_q + ADDR_ONE;
            remain_q <= remain_q - CNT_ONE;
            stb_q    <= 1'b0;
            state_q  <= S_GAP;
          end
        end
        S_GAP: begin
          if ((remain_q == '0) || stop_pend_q || stop) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            stop_pend_q <= 1'b0;
            stb_q       <= 1'b0;
          end else if (!fifo_full_s) begin
            state_q <= S_REQ;
            stb_q   <= 1'b1;
          end else begin
            stb_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          stb_q       <= 1'b0;
          stop_pend_q <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push_s),
    .push_data_i (wbm_readdata),
    .pop_i       (fifo_pop_s),
    .head_o      (out_data),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s),
    .level_o     (fifo_level_s)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign wbm_address   = addr_q;
  assign wbm_strobe    = stb_q;
  assign wbm_cycle     = stb_q;
  assign wbm_write     = 1'b0;
  assign wbm_writedata = '0;
  assign out_valid     = ~fifo_empty_s;
  assign fifo_level    = fifo_level_s;

endmodule

// File: tb/tb_wb_frame_fetch.sv
// Bench for wb_frame_fetch: registered-ack memory slave, a transaction-level
// model of the expected stream, directed scenarios and randomized fetches.
module tb_wb_frame_fetch;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int CW    = 16;
  localparam int DEPTH = 8;
  localparam int FAW   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy, done, wbm_strobe, wbm_cycle, wbm_write, wbm_ack, out_valid;
  logic [AW-1:0] wbm_address;
  logic [DW-1:0] wbm_writedata, wbm_readdata, out_data;
  logic [FAW:0]  fifo_level;

  wb_frame_fetch dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .stop(stop), .busy(busy), .done(done),
    .wbm_address(wbm_address), .wbm_writedata(wbm_writedata),
    .wbm_readdata(wbm_readdata), .wbm_strobe(wbm_strobe), .wbm_cycle(wbm_cycle),
    .wbm_write(wbm_write), .wbm_ack(wbm_ack), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'hA500_0000 + {16'h0000, a} - 32'h0000_0100;
  endfunction

  // Memory slave: ack one cycle after STB&CYC, readdata registered from the address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbm_ack      <= 1'b0;
      wbm_readdata <= '0;
    end else begin
      wbm_ack      <= wbm_strobe & wbm_cycle & ~wbm_ack;
      wbm_readdata <= mem_word(wbm_address);
    end
  end

  int rdy_mode = 1;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  // Model state: expected stream contents and current fetch bookkeeping.
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [15:0] addr_log[$];
  bit          m_active = 1'b0;
  bit          last_ack = 1'b0;
  bit          prev_stb = 1'b0;
  int          m_due = 0;
  int          m_reads = 0;
  int          m_limit = 0;
  logic [15:0] m_base = '0;
  int          done_count = 0;
  int          stb_cycles = 0;
  int          busy_cycles = 0;

  always @(negedge clk) begin
    int          sz;
    bit          exp_done;
    logic [15:0] a_exp;
    if (reset) begin
      exp_q.delete();
      m_active = 1'b0;
      m_due    = 0;
      m_reads  = 0;
      m_limit  = 0;
      last_ack = 1'b0;
      prev_stb = 1'b0;
    end else begin
      sz       = exp_q.size();
      exp_done = (m_due == 1);
      if (exp_done) m_active = 1'b0;
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(m_active));
      chk("fifo_level", 32'(fifo_level), 32'(sz));
      chk("out_valid", 32'(out_valid), 32'(sz != 0));
      chk("cyc_eq_stb", 32'(wbm_cycle), 32'(wbm_strobe));
      chk("write_tied", 32'(wbm_write), 32'd0);
      chk("wdata_tied", wbm_writedata, 32'd0);
      if (done) done_count++;
      if (busy) busy_cycles++;
      if (wbm_strobe) begin
        stb_cycles++;
        chk("stb_legal", 32'(m_active && (m_reads < m_limit) && !last_ack), 32'd1);
      end
      if (prev_stb && !last_ack) chk("stb_held", 32'(wbm_strobe), 32'd1);
      if (m_due != 0) m_due--;
      if (out_valid && out_ready && sz != 0) begin
        chk("out_data", out_data, exp_q[0]);
        got_q.push_back(out_data);
        void'(exp_q.pop_front());
      end
      if (m_active && wbm_strobe && stop && (m_reads + 1 < m_limit)) m_limit = m_reads + 1;
      last_ack = wbm_strobe && wbm_ack;
      if (last_ack && m_active) begin
        a_exp = m_base + 16'(m_reads);
        chk("address", 32'(wbm_address), 32'(a_exp));
        chk("no_overflow", 32'(sz < DEPTH), 32'd1);
        addr_log.push_back(wbm_address);
        exp_q.push_back(mem_word(a_exp));
        m_reads++;
        if (m_reads == m_limit) m_due = 2;
      end
      if (start && !m_active) begin
        if (word_count == '0) begin
          m_due = 1;
        end else begin
          m_active = 1'b1;
          m_base   = base_addr;
          m_limit  = int'(word_count);
          m_reads  = 0;
        end
      end
      prev_stb = wbm_strobe;
    end
  end

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] n);
    @(posedge clk);
    #1;
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && done_count == d0; i++) @(posedge clk);
    chk("done_timeout", 32'(done_count != d0), 32'd1);
  endtask

  // smode: 0 no stop, 1 random stop during a strobe, 2 stop on the 3rd read
  task automatic run_fetch(input logic [15:0] b, input logic [15:0] n, input int smode);
    int d0;
    bit fired;
    fired = 1'b0;
    d0    = done_count;
    pulse_start(b, n);
    for (int i = 0; i < 2000 && done_count == d0; i++) begin
      @(posedge clk);
      #1;
      stop = 1'b0;
      if (!fired && wbm_strobe &&
          ((smode == 1 && $urandom_range(0, 3) == 0) || (smode == 2 && m_reads == 2))) begin
        stop  = 1'b1;
        fired = 1'b1;
      end
    end
    stop = 1'b0;
    chk("done_timeout", 32'(done_count != d0), 32'd1);
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_logs();
    got_q.delete();
    addr_log.delete();
  endtask

  task automatic test_basic();
    int d0;
    clear_logs();
    rdy_mode = 1;
    d0 = done_count;
    run_fetch(16'h0100, 16'd5, 0);
    drain();
    chk("basic_done_pulses", 32'(done_count - d0), 32'd1);
    chk("basic_reads", 32'(addr_log.size()), 32'd5);
    chk("basic_words", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < addr_log.size()) chk("basic_addr", 32'(addr_log[i]), 32'h0100 + 32'(i));
      if (i < got_q.size()) chk("basic_data", got_q[i], 32'hA500_0000 + 32'(i));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0, s0, b0;
    logic [15:0] wrap_exp [4];
    logic [15:0] rb, rn;
    int          sm;
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobe", 32'(wbm_strobe), 32'd0);
    chk("rst_cycle", 32'(wbm_cycle), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_addr", 32'(wbm_address), 32'd0);
    reset = 1'b0;

    test_basic();

    s0 = stb_cycles;
    b0 = busy_cycles;
    d0 = done_count;
    pulse_start(16'h0400, 16'd0);
    wait_done(d0, 20);
    repeat (4) @(posedge clk);
    chk("zero_strobes", 32'(stb_cycles - s0), 32'd0);
    chk("zero_busy", 32'(busy_cycles - b0), 32'd0);
    chk("zero_done_pulses", 32'(done_count - d0), 32'd1);

    clear_logs();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    d0 = done_count;
    pulse_start(16'h0200, 16'd12);
    repeat (60) @(posedge clk);
    #1;
    chk("stall_reads", 32'(addr_log.size()), 32'd8);
    chk("stall_level", 32'(fifo_level), 32'd8);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_strobe", 32'(wbm_strobe), 32'd0);
    rdy_mode = 1;
    wait_done(d0, 500);
    drain();
    chk("stall_total_reads", 32'(addr_log.size()), 32'd12);
    chk("stall_words", 32'(got_q.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < got_q.size()) chk("stall_data", got_q[i], 32'hA500_0100 + 32'(i));
    end

    clear_logs();
    d0 = done_count;
    run_fetch(16'h0300, 16'd10, 2);
    drain();
    chk("stop_reads", 32'(addr_log.size()), 32'd3);
    chk("stop_words", 32'(got_q.size()), 32'd3);
    chk("stop_done_pulses", 32'(done_count - d0), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) chk("stop_data", got_q[i], 32'hA500_0200 + 32'(i));
    end

    clear_logs();
    run_fetch(16'hFFFE, 16'd4, 0);
    drain();
    chk("wrap_reads", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < addr_log.size()) chk("wrap_addr", 32'(addr_log[i]), 32'(wrap_exp[i]));
    end

    clear_logs();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    pulse_start(16'h0500, 16'd10);
    for (int i = 0; i < 100 && !(m_reads >= 2 && wbm_strobe); i++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_setup_stb", 32'(wbm_strobe), 32'd1);
    chk("rst_mid_setup_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_strobe", 32'(wbm_strobe), 32'd0);
    chk("rst_mid_cycle", 32'(wbm_cycle), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_level", 32'(fifo_level), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    test_basic();

    for (int it = 0; it < 40; it++) begin
      rdy_mode = ($urandom_range(0, 2) == 0) ? 3 : 2;
      rb = 16'($urandom_range(0, 65535));
      rn = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
      sm = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_fetch(rb, rn, sm);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_frame_fetch.md
Name: wb_frame_fetch

Overview:
- Wishbone master that reads a contiguous block of 32-bit words from the on-chip frame memory slave and streams them to the LED output stage through a small internal FIFO.
- Sits directly upstream of the memory slave. It drives that slave's address, strobe, cycle and write inputs and consumes its readdata and ack.
- Control logic pulses start with a base address and word count, then waits for done.

Parameters:
- ADDR_WIDTH, 16: Wishbone address width. Full bus address, including the slave base; the slave strips the base itself.
- DATA_WIDTH, 32: Wishbone and stream data width.
- CNT_WIDTH, 16: width of the word_count input and the internal remaining counter.
- FIFO_DEPTH, 8: output FIFO depth in words. Power of two, at least 2.
- FIFO_AW, 3: log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that launches a fetch; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address, latched on start
- word_count  in  CNT_WIDTH  number of words to fetch, latched on start
- stop  in  1  abort request; the fetch ends after the current bus transfer completes
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse when a fetch ends (normally or by stop)
- wbm_address  out  ADDR_WIDTH  current read address
- wbm_writedata  out  DATA_WIDTH  tied to 0
- wbm_readdata  in  DATA_WIDTH  slave read data
- wbm_strobe  out  1  Wishbone STB
- wbm_cycle  out  1  Wishbone CYC, always equal to wbm_strobe
- wbm_write  out  1  tied to 0; this block is read-only
- wbm_ack  in  1  slave ACK
- out_data  out  DATA_WIDTH  FIFO head word (first-word fall-through)
- out_valid  out  1  FIFO not empty
- out_ready  in  1  downstream accepts; a pop occurs when out_valid & out_ready
- fifo_level  out  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset is asynchronous. It clears state to IDLE and forces busy, done, wbm_strobe, wbm_cycle, out_valid and fifo_level to 0. wbm_address resets to 0. The FIFO is emptied and stop_pending is cleared.
- A reset asserted mid-transfer drops strobe immediately. No ack is awaited and FIFO contents are lost.
- The FSM has three states:
  - IDLE. On start with word_count != 0: latch addr = base_addr and remaining = word_count, then go to REQ, or to GAP if the FIFO is full. On start with word_count == 0: no bus activity, done pulses in the next cycle, stay in IDLE. Start is ignored outside IDLE.
  - REQ. Assert strobe and cycle with wbm_address = addr, and hold them until ack; a request is never withdrawn early. On ack: push wbm_readdata into the FIFO, addr <= addr + 1 (wraps modulo 2^ADDR_WIDTH), remaining <= remaining - 1, then go to GAP.
  - GAP. Strobe is low for at least one cycle. This lets the slave's registered ack clear; the slave gates ack only by STB&CYC, so back-to-back strobes would produce a false ack. In GAP:
    - If remaining == 0 or stop_pending: go to IDLE, with done high in the following cycle.
    - Otherwise, if fifo_level < FIFO_DEPTH: go to REQ.
    - Otherwise, stay in GAP (back-pressure stall).
- Slave read latency is one cycle. Best-case throughput is one word per 3 clocks: REQ, ACK (still REQ), GAP.
- There is only one outstanding request. A request is issued only with a free FIFO slot, so a push never overflows. A simultaneous push and pop leaves fifo_level unchanged.
- stop in any non-IDLE state sets stop_pending. It takes effect at the next GAP, so an in-flight read completes and its word is pushed. stop in IDLE has no effect. stop_pending clears on entry to IDLE.
- FIFO contents survive the end of a fetch and continue draining. A new start may launch while the FIFO is non-empty.

Decomposition:
- Shared package/header: the FSM state encodings (S_IDLE, S_REQ, S_GAP) and default widths.
- One sub-module: sync_fifo. It is parameterised by width and depth, with first-word fall-through, outputs for empty, full and level, and asynchronous reset. It is reusable by other stream stages.

Test Plan:
- Memory preloaded with mem[0x0100+i] = 0xA5000000+i; start with base_addr=0x0100 and word_count=5, out_ready=1. Required: 5 bus reads at addresses 0x0100..0x0104, out_data sequence 0xA5000000..0xA5000004, strobe low for at least 1 cycle between transfers, done pulses once, busy falls with done.
- word_count=0 -> no strobe ever, done high for exactly 1 cycle, busy stays 0.
- out_ready=0 with word_count=12 -> exactly 8 reads, then the FSM stalls in GAP with fifo_level=8. Raising out_ready -> the remaining 4 reads complete, and all 12 words arrive in order.
- stop pulsed while strobe is high on the 3rd read of a 10-word fetch -> the 3rd ack is honoured, exactly 3 words are pushed, done pulses, there is no 4th strobe.
- base_addr=0xFFFE, word_count=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- reset asserted while strobe is high -> strobe, busy and out_valid drop asynchronously, fifo_level=0. A new start after reset behaves as in the first scenario.
